// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide memory controller and its clients.
// Holds bus width defaults, request width encodings, IO address decode and FSM states.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] WIDTH_B = 3'd1;
    localparam logic [2:0] WIDTH_H = 3'd2;
    localparam logic [2:0] WIDTH_W = 3'd4;

    // An address is IO space when addr[IO_HI:IO_LO] equals IO_SEL.
    localparam int         IO_HI      = 17;
    localparam int         IO_LO      = 16;
    localparam logic [1:0] IO_SEL_DEF = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        IF_READ,
        LSB_READ,
        LSB_WRITE,
        DONE
    } state_e;

    typedef enum logic {
        GRANT_IF,
        GRANT_LSB
    } grant_e;

    // Unsupported widths fall back to a full word.
    function automatic logic [2:0] width_to_n(input logic [2:0] w);
        case (w)
            WIDTH_B: return WIDTH_B;
            WIDTH_H: return WIDTH_H;
            default: return WIDTH_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the RAM port, the IF and LSB request channels and the global controls.
// The controller uses the slave side; the surrounding core and RAM use the master side.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              rdy;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    logic              enable_from_if;
    logic [ADDR_W-1:0] addr_from_if;
    logic              ok_to_if;
    logic [DATA_W-1:0] data_to_if;

    logic              enable_from_lsb;
    logic              read_or_write_from_lsb;
    logic [ADDR_W-1:0] addr_from_lsb;
    logic [DATA_W-1:0] data_from_lsb;
    logic [2:0]        width_from_lsb;
    logic              ok_to_lsb;
    logic [DATA_W-1:0] data_to_lsb;

    logic              mispredict;

    modport slave (
        input  rdy, mem_din, io_buffer_full,
        input  enable_from_if, addr_from_if,
        input  enable_from_lsb, read_or_write_from_lsb, addr_from_lsb,
        input  data_from_lsb, width_from_lsb, mispredict,
        output mem_dout, mem_a, mem_wr,
        output ok_to_if, data_to_if, ok_to_lsb, data_to_lsb
    );

    modport master (
        output rdy, mem_din, io_buffer_full,
        output enable_from_if, addr_from_if,
        output enable_from_lsb, read_or_write_from_lsb, addr_from_lsb,
        output data_from_lsb, width_from_lsb, mispredict,
        input  mem_dout, mem_a, mem_wr,
        input  ok_to_if, data_to_if, ok_to_lsb, data_to_lsb
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the load/store buffer,
// splitting each request into byte cycles and assembling read data little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter int         DATA_W = DATA_W_DEF,
    parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    state_e            state_q;
    grant_e            last_grant_q;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;
    logic              ok_if_q;
    logic              ok_lsb_q;
    logic [DATA_W-1:0] data_if_q;
    logic [DATA_W-1:0] data_lsb_q;

    logic              req_d;
    logic              grant_lsb_d;
    logic [2:0]        lsb_n_d;
    logic              lsb_issue_d;
    logic              cur_issue_d;
    logic [1:0]        rd_idx_d;
    logic [DATA_W-1:0] rdata_d;

    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                   input logic [1:0]        k,
                                                   input logic [7:0]        b);
        logic [DATA_W-1:0] r;
        r = w;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[IO_HI:IO_LO] == IO_SEL;
    endfunction

    // Round-robin only matters when both sides request in the same cycle.
    always_comb begin
        req_d       = (bus.enable_from_if || bus.enable_from_lsb) && !bus.mispredict;
        grant_lsb_d = 1'b0;
        if (bus.enable_from_lsb && bus.enable_from_if)
            grant_lsb_d = (last_grant_q == GRANT_IF);
        else if (bus.enable_from_lsb)
            grant_lsb_d = 1'b1;
        lsb_n_d     = width_to_n(bus.width_from_lsb);
        lsb_issue_d = !(is_io(bus.addr_from_lsb) && bus.io_buffer_full);
        cur_issue_d = !(is_io(addr_q) && bus.io_buffer_full);
        rd_idx_d    = cnt_q[1:0] - 2'd1;
        rdata_d     = put_byte(rbuf_q, rd_idx_d, bus.mem_din);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            cnt_q        <= '0;
            n_q          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            ok_if_q      <= 1'b0;
            ok_lsb_q     <= 1'b0;
            data_if_q    <= '0;
            data_lsb_q   <= '0;
        end else if (bus.rdy) begin
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        cnt_q  <= '0;
                        rbuf_q <= '0;
                        if (grant_lsb_d) begin
                            last_grant_q <= GRANT_LSB;
                            n_q          <= lsb_n_d;
                            addr_q       <= bus.addr_from_lsb;
                            mem_a_q      <= bus.addr_from_lsb;
                            if (bus.read_or_write_from_lsb) begin
                                state_q    <= LSB_WRITE;
                                wdata_q    <= bus.data_from_lsb;
                                mem_dout_q <= bus.data_from_lsb[7:0];
                                mem_wr_q   <= lsb_issue_d;
                                cnt_q      <= lsb_issue_d ? 3'd1 : 3'd0;
                            end else begin
                                state_q  <= LSB_READ;
                                mem_wr_q <= 1'b0;
                            end
                        end else begin
                            last_grant_q <= GRANT_IF;
                            n_q          <= WIDTH_W;
                            addr_q       <= bus.addr_from_if;
                            mem_a_q      <= bus.addr_from_if;
                            mem_wr_q     <= 1'b0;
                            state_q      <= IF_READ;
                        end
                    end
                end

                // cnt_q counts edges since accept; byte cnt_q-1 arrives on mem_din now.
                IF_READ, LSB_READ: begin
                    if (bus.mispredict) begin
                        state_q  <= IDLE;
                        mem_wr_q <= 1'b0;
                    end else begin
                        if ((cnt_q + 3'd1) < n_q)
                            mem_a_q <= mem_a_q + ADDR_W'(1);
                        if (cnt_q != 3'd0)
                            rbuf_q <= rdata_d;
                        if (cnt_q == n_q) begin
                            state_q <= DONE;
                            if (state_q == IF_READ) begin
                                ok_if_q   <= 1'b1;
                                data_if_q <= rdata_d;
                            end else begin
                                ok_lsb_q   <= 1'b1;
                                data_lsb_q <= rdata_d;
                            end
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end
                end

                // cnt_q counts bytes already put on the port; stores ignore mispredict.
                LSB_WRITE: begin
                    if (cnt_q == n_q) begin
                        mem_wr_q <= 1'b0;
                        ok_lsb_q <= 1'b1;
                        state_q  <= DONE;
                    end else if (!cur_issue_d) begin
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_a_q    <= addr_q + ADDR_W'(cnt_q);
                        mem_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        mem_wr_q   <= 1'b1;
                        cnt_q      <= cnt_q + 3'd1;
                    end
                end

                DONE: begin
                    ok_if_q  <= 1'b0;
                    ok_lsb_q <= 1'b0;
                    state_q  <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_a       = mem_a_q;
    assign bus.mem_dout    = mem_dout_q;
    assign bus.mem_wr      = mem_wr_q && bus.rdy;
    assign bus.ok_to_if    = ok_if_q;
    assign bus.data_to_if  = data_if_q;
    assign bus.ok_to_lsb   = ok_lsb_q;
    assign bus.data_to_lsb = data_lsb_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model on the port and hand-computed expectations.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    logic [7:0] ram [0:4095];

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM folds addr[17:16] and addr[9:0] into the index so IO space gets its own bytes.
    function automatic int ridx(input logic [31:0] a);
        return int'({a[17:16], a[9:0]});
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wr)
            ram[ridx(bus.mem_a)] <= bus.mem_dout;
        bus.mem_din <= ram[ridx(bus.mem_a)];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_mem_wr"},   32'(bus.mem_wr), 32'd0);
        chk({tag, "_mem_a"},    bus.mem_a, 32'd0);
        chk({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'd0);
        chk({tag, "_ok_if"},    32'(bus.ok_to_if), 32'd0);
        chk({tag, "_ok_lsb"},   32'(bus.ok_to_lsb), 32'd0);
        chk({tag, "_data_if"},  bus.data_to_if, 32'd0);
        chk({tag, "_data_lsb"}, bus.data_to_lsb, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h202] = 8'h5A;
        ram[12'h000] = 8'hA0; ram[12'h001] = 8'hA1; ram[12'h002] = 8'hA2; ram[12'h003] = 8'hA3;
        ram[12'h010] = 8'h01; ram[12'h011] = 8'h02; ram[12'h012] = 8'h03; ram[12'h013] = 8'h04;

        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus.enable_from_if = 1'b0;
        bus.addr_from_if = '0;
        bus.enable_from_lsb = 1'b0;
        bus.read_or_write_from_lsb = 1'b0;
        bus.addr_from_lsb = '0;
        bus.data_from_lsb = '0;
        bus.width_from_lsb = 3'd0;
        bus.mispredict = 1'b0;
        step(2);
        chk_outputs_reset("reset");
        rst = 1'b0;
        step(1);

        // Test 1: LW at 0x100
        bus.enable_from_lsb = 1'b1;
        bus.read_or_write_from_lsb = 1'b0;
        bus.addr_from_lsb = 32'h100;
        bus.width_from_lsb = 3'd4;
        step(1);
        chk("t1_a0", bus.mem_a, 32'h100);
        chk("t1_wr0", 32'(bus.mem_wr), 32'd0);
        step(1); chk("t1_a1", bus.mem_a, 32'h101);
        step(1); chk("t1_a2", bus.mem_a, 32'h102);
        step(1); chk("t1_a3", bus.mem_a, 32'h103);
        step(1); chk("t1_ok_early", 32'(bus.ok_to_lsb), 32'd0);
        step(1);
        chk("t1_ok", 32'(bus.ok_to_lsb), 32'd1);
        chk("t1_data", bus.data_to_lsb, 32'h44332211);
        chk("t1_ok_if", 32'(bus.ok_to_if), 32'd0);
        bus.enable_from_lsb = 1'b0;
        step(1);
        chk("t1_ok_pulse", 32'(bus.ok_to_lsb), 32'd0);
        chk("t1_data_hold", bus.data_to_lsb, 32'h44332211);

        // Test 2: SH at 0x200
        bus.enable_from_lsb = 1'b1;
        bus.read_or_write_from_lsb = 1'b1;
        bus.addr_from_lsb = 32'h200;
        bus.data_from_lsb = 32'hAABBCCDD;
        bus.width_from_lsb = 3'd2;
        step(1);
        chk("t2_a0", bus.mem_a, 32'h200);
        chk("t2_d0", 32'(bus.mem_dout), 32'hDD);
        chk("t2_wr0", 32'(bus.mem_wr), 32'd1);
        step(1);
        chk("t2_a1", bus.mem_a, 32'h201);
        chk("t2_d1", 32'(bus.mem_dout), 32'hCC);
        chk("t2_wr1", 32'(bus.mem_wr), 32'd1);
        chk("t2_ok_early", 32'(bus.ok_to_lsb), 32'd0);
        step(1);
        chk("t2_wr_drop", 32'(bus.mem_wr), 32'd0);
        chk("t2_ok", 32'(bus.ok_to_lsb), 32'd1);
        chk("t2_data_hold", bus.data_to_lsb, 32'h44332211);
        bus.enable_from_lsb = 1'b0;
        step(1);
        chk("t2_ok_pulse", 32'(bus.ok_to_lsb), 32'd0);
        chk("t2_ram200", 32'(ram[12'h200]), 32'hDD);
        chk("t2_ram201", 32'(ram[12'h201]), 32'hCC);
        chk("t2_ram202", 32'(ram[12'h202]), 32'h5A);

        // Test 3: simultaneous requests from reset, LSB first
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.enable_from_if = 1'b1;
        bus.addr_from_if = 32'h100;
        bus.enable_from_lsb = 1'b1;
        bus.read_or_write_from_lsb = 1'b0;
        bus.addr_from_lsb = 32'h102;
        bus.width_from_lsb = 3'd1;
        step(1);
        chk("t3_lsb_first", bus.mem_a, 32'h102);
        step(1);
        chk("t3_lsb_ok_early", 32'(bus.ok_to_lsb), 32'd0);
        step(1);
        chk("t3_lsb_ok", 32'(bus.ok_to_lsb), 32'd1);
        chk("t3_if_not_ok", 32'(bus.ok_to_if), 32'd0);
        chk("t3_lsb_data", bus.data_to_lsb, 32'h00000033);
        bus.enable_from_lsb = 1'b0;
        step(1);
        chk("t3_done_lsb", 32'(bus.ok_to_lsb), 32'd0);
        chk("t3_done_if", 32'(bus.ok_to_if), 32'd0);
        step(1);
        chk("t3_if_accept", bus.mem_a, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t3_if_wait", 32'({bus.ok_to_if, bus.ok_to_lsb}), 32'd0);
        end
        step(1);
        chk("t3_if_ok", 32'(bus.ok_to_if), 32'd1);
        chk("t3_lsb_quiet", 32'(bus.ok_to_lsb), 32'd0);
        chk("t3_if_data", bus.data_to_if, 32'h44332211);
        bus.enable_from_if = 1'b0;
        step(1);
        chk("t3_if_pulse", 32'(bus.ok_to_if), 32'd0);

        // Test 4: SB to IO space with the IO buffer full for three edges
        bus.enable_from_lsb = 1'b1;
        bus.read_or_write_from_lsb = 1'b1;
        bus.addr_from_lsb = 32'h00030000;
        bus.data_from_lsb = 32'h000000E7;
        bus.width_from_lsb = 3'd1;
        bus.io_buffer_full = 1'b1;
        step(1);
        chk("t4_a", bus.mem_a, 32'h00030000);
        chk("t4_stall0", 32'(bus.mem_wr), 32'd0);
        step(1); chk("t4_stall1", 32'(bus.mem_wr), 32'd0);
        step(1); chk("t4_stall2", 32'(bus.mem_wr), 32'd0);
        chk("t4_no_ok", 32'(bus.ok_to_lsb), 32'd0);
        bus.io_buffer_full = 1'b0;
        step(1);
        chk("t4_wr", 32'(bus.mem_wr), 32'd1);
        chk("t4_dout", 32'(bus.mem_dout), 32'hE7);
        step(1);
        chk("t4_wr_drop", 32'(bus.mem_wr), 32'd0);
        chk("t4_ok", 32'(bus.ok_to_lsb), 32'd1);
        bus.enable_from_lsb = 1'b0;
        step(1);
        chk("t4_ram", 32'(ram[12'hC00]), 32'hE7);

        // Test 5: IF read at 0x0 flushed by mispredict on accept+2
        bus.enable_from_if = 1'b1;
        bus.addr_from_if = 32'h0;
        step(1);
        chk("t5_a0", bus.mem_a, 32'h0);
        step(1);
        bus.mispredict = 1'b1;
        step(1);
        bus.mispredict = 1'b0;
        bus.enable_from_if = 1'b0;
        chk("t5_state", 32'(dut.state_q), 32'(IDLE));
        chk("t5_wr", 32'(bus.mem_wr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t5_no_ok", 32'(bus.ok_to_if), 32'd0);
        end
        chk("t5_data_hold", bus.data_to_if, 32'h44332211);
        bus.enable_from_if = 1'b1;
        bus.addr_from_if = 32'h10;
        step(1);
        chk("t5_reaccept", bus.mem_a, 32'h10);
        step(4);
        chk("t5_ok_early", 32'(bus.ok_to_if), 32'd0);
        step(1);
        chk("t5_ok", 32'(bus.ok_to_if), 32'd1);
        chk("t5_data", bus.data_to_if, 32'h04030201);
        bus.enable_from_if = 1'b0;
        step(1);

        // rdy low freezes the controller and masks mem_wr
        bus.enable_from_lsb = 1'b1;
        bus.read_or_write_from_lsb = 1'b1;
        bus.addr_from_lsb = 32'h40;
        bus.data_from_lsb = 32'h0000009C;
        bus.width_from_lsb = 3'd1;
        step(1);
        chk("rdy_wr_before", 32'(bus.mem_wr), 32'd1);
        bus.rdy = 1'b0;
        #1;
        chk("rdy_wr_masked", 32'(bus.mem_wr), 32'd0);
        step(2);
        chk("rdy_a_frozen", bus.mem_a, 32'h40);
        chk("rdy_no_ok", 32'(bus.ok_to_lsb), 32'd0);
        chk("rdy_ram_untouched", 32'(ram[12'h040]), 32'h00);
        bus.rdy = 1'b1;
        step(1);
        chk("rdy_ok", 32'(bus.ok_to_lsb), 32'd1);
        chk("rdy_ram", 32'(ram[12'h040]), 32'h9C);
        bus.enable_from_lsb = 1'b0;
        step(1);

        // Test 6: asynchronous reset in the middle of an SW
        bus.enable_from_lsb = 1'b1;
        bus.read_or_write_from_lsb = 1'b1;
        bus.addr_from_lsb = 32'h300;
        bus.data_from_lsb = 32'h12345678;
        bus.width_from_lsb = 3'd4;
        step(2);
        chk("t6_wr_mid", 32'(bus.mem_wr), 32'd1);
        chk("t6_a_mid", bus.mem_a, 32'h301);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_reset("t6_async");
        step(1);
        bus.enable_from_lsb = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t6_no_ok", 32'({bus.ok_to_if, bus.ok_to_lsb}), 32'd0);
        end
        chk("t6_partial_ram", 32'(ram[12'h303]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
